// File: rtl/oam_dma_writer.sv
// OAM write side: CPU $2003/$2004 register writes and $4014 page DMA into the 256-byte primary OAM.
// Optional build macro OAM_ATTR_MASK_EN: clears bits 4:2 of every attribute byte (addr[1:0]==2) written to OAM.
module oam_dma_writer #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [2:0]  PPU_BASE = 3'b001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_cycle_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_we,
    input  logic        rendering,
    input  logic [7:0]  mem_data_in,
    output logic        dma_rdy,
    output logic        dma_busy,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data_out,
    output logic        oam_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        parity;
    logic [7:0]  oamaddr;
    logic [7:0]  page;
    logic [7:0]  cnt;

    logic        wr_strobe;
    logic        ppu_sel;
    logic        reg_oamaddr_wr;
    logic        reg_oamdata_wr;
    logic        dma_trig;

    logic        wr_fire;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_raw;
    logic [7:0]  wr_data;

    // CPU writes are dropped while the DMA owns the bus
    assign wr_strobe      = cpu_we && cpu_cycle_en && !dma_busy;
    assign ppu_sel        = (cpu_addr[15:13] == PPU_BASE);
    assign reg_oamaddr_wr = wr_strobe && ppu_sel && (cpu_addr[2:0] == 3'd3);
    assign reg_oamdata_wr = wr_strobe && ppu_sel && (cpu_addr[2:0] == 3'd4);
    assign dma_trig       = wr_strobe && (cpu_addr == DMA_REG);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; every DMA step waits for a CPU cycle strobe
    always_comb begin
        state_nxt = state;
        if (cpu_cycle_en) begin
            case (state)
                S_IDLE:  if (dma_trig) state_nxt = S_HALT;
                // parity here belongs to the dummy cycle; reads must land on get cycles
                S_HALT:  state_nxt = parity ? S_READ : S_ALIGN;
                S_ALIGN: state_nxt = S_READ;
                S_READ:  state_nxt = S_WRITE;
                S_WRITE: state_nxt = (cnt == 8'hFF) ? S_DONE : S_READ;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        dma_busy = 1'b0;
        dma_rdy  = 1'b1;
        dma_rd   = 1'b0;
        case (state)
            S_HALT, S_ALIGN, S_WRITE: begin
                dma_busy = 1'b1;
                dma_rdy  = 1'b0;
            end
            S_READ: begin
                dma_busy = 1'b1;
                dma_rdy  = 1'b0;
                dma_rd   = cpu_cycle_en;
            end
            default: ;
        endcase
    end

    assign dma_addr = {page, cnt};

    // Parity, OAMADDR, DMA page and byte counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity  <= 1'b0;
            oamaddr <= 8'h00;
            page    <= 8'h00;
            cnt     <= 8'h00;
        end else if (cpu_cycle_en) begin
            parity <= ~parity;
            if (state == S_IDLE && dma_trig)
                page <= cpu_data_in;
            if (state == S_WRITE)
                cnt <= cnt + 8'd1;
            if (reg_oamaddr_wr)
                oamaddr <= cpu_data_in;
            else if (reg_oamdata_wr && !rendering)
                oamaddr <= oamaddr + 8'd1;
        end
    end

    // One shared OAM write port; DMA and CPU writes are mutually exclusive via dma_busy
    always_comb begin
        wr_fire = cpu_cycle_en && ((state == S_WRITE) || (reg_oamdata_wr && !rendering));
        wr_addr = (state == S_WRITE) ? (oamaddr + cnt) : oamaddr;
        wr_raw  = (state == S_WRITE) ? mem_data_in : cpu_data_in;
    end

`ifdef OAM_ATTR_MASK_EN
    assign wr_data = (wr_addr[1:0] == 2'd2) ? (wr_raw & 8'hE3) : wr_raw;
`else
    assign wr_data = wr_raw;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oam_we       <= 1'b0;
            oam_addr     <= 8'h00;
            oam_data_out <= 8'h00;
        end else begin
            oam_we <= wr_fire;
            if (wr_fire) begin
                oam_addr     <= wr_addr;
                oam_data_out <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_writer.sv
// Directed + randomized bench for oam_dma_writer against a behavioural OAM/DMA model.
module tb_oam_dma_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_cycle_en = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_data_in = 8'h0;
    logic        cpu_we = 1'b0;
    logic        rendering = 1'b0;
    logic [7:0]  mem_data_in = 8'h0;
    logic        dma_rdy, dma_busy, dma_rd, oam_we;
    logic [15:0] dma_addr;
    logic [7:0]  oam_addr, oam_data_out;

    oam_dma_writer dut (
        .clk(clk), .reset(reset), .cpu_cycle_en(cpu_cycle_en), .cpu_addr(cpu_addr),
        .cpu_data_in(cpu_data_in), .cpu_we(cpu_we), .rendering(rendering),
        .mem_data_in(mem_data_in), .dma_rdy(dma_rdy), .dma_busy(dma_busy),
        .dma_addr(dma_addr), .dma_rd(dma_rd), .oam_addr(oam_addr),
        .oam_data_out(oam_data_out), .oam_we(oam_we)
    );

    always #5 clk = ~clk;

    int          nerr = 0;
    int          nchk = 0;
    int          ncyc = 0;
    int          nwr = 0;
    int          stray = 0;
    int          halt_cnt = 0;
    logic [7:0]  tb_oam [256];
    logic [15:0] rd_q [$];
    logic [7:0]  nxt_mem = 8'h0;
    logic        got_we;
    logic [7:0]  got_a, got_d;
    logic [7:0]  oamaddr_m = 8'h0;

    function automatic logic [7:0] mdl_mask(input logic [7:0] a, input logic [7:0] d);
`ifdef OAM_ATTR_MASK_EN
        return (a % 4 == 2) ? (d & 8'hE3) : d;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: strobe for one clk, then two quiet clks. Entered/left at posedge+1.
    task automatic cyc(input logic we, input logic [15:0] a, input logic [7:0] d);
        logic pre_rdy;
        cpu_we = we; cpu_addr = a; cpu_data_in = d; cpu_cycle_en = 1'b1;
        #1;
        pre_rdy = dma_rdy;
        if (dma_rd) begin
            rd_q.push_back(dma_addr);
            nxt_mem = dma_addr[7:0] ^ 8'h5A;
        end
        @(posedge clk); #1;
        cpu_cycle_en = 1'b0; cpu_we = 1'b0;
        mem_data_in = nxt_mem;
        if (!pre_rdy) halt_cnt++;
        ncyc++;
        got_we = oam_we; got_a = oam_addr; got_d = oam_data_out;
        if (oam_we) begin tb_oam[oam_addr] = oam_data_out; nwr++; end
        repeat (2) begin
            @(posedge clk); #1;
            if (oam_we || dma_rd) stray++;
        end
    endtask

    task automatic run_dma(input string tag, input logic [7:0] pg, input logic [7:0] start,
                           input bit put);
        int bad_rd, bad_oam, w0;
        cyc(1'b1, 16'h2003, start);
        oamaddr_m = start;
        if ((ncyc % 2 == 1) != put) cyc(1'b0, 16'h0, 8'h0);
        rd_q.delete(); halt_cnt = 0; w0 = nwr;
        cyc(1'b1, 16'h4014, pg);
        chk({tag, "_busy"}, {dma_busy, dma_rdy}, 2'b10);
        repeat (530) cyc(1'b0, 16'h0, 8'h0);
        chk({tag, "_halt"}, halt_cnt, put ? 514 : 513);
        chk({tag, "_nwr"}, nwr - w0, 256);
        chk({tag, "_nrd"}, rd_q.size(), 256);
        bad_rd = 0; bad_oam = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] oa;
            oa = 8'((start + i) % 256);
            if (i < rd_q.size() && rd_q[i] !== 16'(pg * 256 + i)) bad_rd++;
            if (tb_oam[oa] !== mdl_mask(oa, 8'(i) ^ 8'h5A)) bad_oam++;
        end
        chk({tag, "_rdseq"}, bad_rd, 0);
        chk({tag, "_oam"}, bad_oam, 0);
        chk({tag, "_idle"}, {dma_busy, dma_rdy}, 2'b01);
    endtask

    initial begin
        int w0;
        logic [15:0] addrs [7];
        addrs = '{16'h2003, 16'h2004, 16'h200B, 16'h3FFC, 16'h2005, 16'h6004, 16'h2007};
        for (int i = 0; i < 256; i++) tb_oam[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rdy", dma_rdy, 1'b1);
        chk("rst_busy", dma_busy, 1'b0);
        chk("rst_we", oam_we, 1'b0);
        chk("rst_oam_addr", oam_addr, 8'h00);
        chk("rst_dma_addr", dma_addr, 16'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Register writes
        cyc(1'b1, 16'h2003, 8'h05);
        chk("oamaddr_no_we", got_we, 1'b0);
        cyc(1'b1, 16'h2004, 8'hAB);
        chk("wr1", {got_we, got_a, got_d}, {1'b1, 8'h05, mdl_mask(8'h05, 8'hAB)});
        cyc(1'b1, 16'h2004, 8'hCD);
        chk("wr2", {got_we, got_a, got_d}, {1'b1, 8'h06, mdl_mask(8'h06, 8'hCD)});
        rendering = 1'b1;
        cyc(1'b1, 16'h2004, 8'h11);
        chk("wr_render", got_we, 1'b0);
        rendering = 1'b0;
        cyc(1'b1, 16'h2004, 8'h22);
        chk("wr_after_render", {got_we, got_a, got_d}, {1'b1, 8'h07, mdl_mask(8'h07, 8'h22)});
        oamaddr_m = 8'h08;

        // Randomized register traffic vs. behavioural OAMADDR model
        for (int k = 0; k < 40; k++) begin
            logic [15:0] a;
            logic [7:0]  d;
            logic        r, ew;
            logic [7:0]  ea, ed;
            a = addrs[$urandom_range(0, 6)];
            d = 8'($urandom);
            r = 1'($urandom_range(0, 1));
            ew = 1'b0; ea = 8'h0; ed = 8'h0;
            if (a[15:13] == 3'b001 && a[2:0] == 3'd3) oamaddr_m = d;
            else if (a[15:13] == 3'b001 && a[2:0] == 3'd4 && !r) begin
                ew = 1'b1; ea = oamaddr_m; ed = mdl_mask(oamaddr_m, d);
                oamaddr_m = oamaddr_m + 8'd1;
            end
            rendering = r;
            cyc(1'b1, a, d);
            rendering = 1'b0;
            if (ew) chk("rand_wr", {got_we, got_a, got_d}, {1'b1, ea, ed});
            else    chk("rand_nowr", got_we, 1'b0);
        end

        // DMA: get-cycle trigger, put-cycle trigger, wrapped start, random page/offset
        run_dma("dma_get", 8'h02, 8'h00, 1'b0);
        run_dma("dma_put", 8'h02, 8'h00, 1'b1);
        run_dma("dma_wrap", 8'h03, 8'hFE, 1'b0);
        chk("wrap_b0", tb_oam[8'hFE], mdl_mask(8'hFE, 8'h00 ^ 8'h5A));
        chk("wrap_b2", tb_oam[8'h00], mdl_mask(8'h00, 8'h02 ^ 8'h5A));
        cyc(1'b1, 16'h2004, 8'h77);
        chk("oamaddr_kept", {got_we, got_a}, {1'b1, 8'hFE});
        run_dma("dma_rand", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        // Reset in the middle of a DMA
        cyc(1'b1, 16'h2003, 8'h00);
        cyc(1'b1, 16'h4014, 8'h04);
        w0 = nwr;
        for (int b = 0; b < 600 && (nwr - w0) < 100; b++) cyc(1'b0, 16'h0, 8'h0);
        chk("reach_byte100", (nwr - w0) >= 100, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_rdy", dma_rdy, 1'b1);
        chk("midrst_busy", dma_busy, 1'b0);
        chk("midrst_we", oam_we, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        ncyc = 0; oamaddr_m = 8'h00;
        w0 = nwr;
        repeat (20) cyc(1'b0, 16'h0, 8'h0);
        chk("midrst_no_wr", nwr - w0, 0);

        // Attribute-byte write through $2004
        cyc(1'b1, 16'h2003, 8'h02);
        cyc(1'b1, 16'h2004, 8'hFF);
        chk("attr_wr", {got_we, got_a, got_d}, {1'b1, 8'h02, mdl_mask(8'h02, 8'hFF)});

        chk("stray_pulses", stray, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
